bcd_addsub_seq: RTL and testbench

BCD_ADDSUB_SEQ -- requirements
Module: bcd_addsub_seq

---
 rtl/bcd_pkg.sv | 17 +
 rtl/bcd_digit_add.sv | 29 ++
 rtl/bcd_addsub_seq.sv | 127 ++++++++++++
 tb/tb_bcd_addsub_seq.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the digit-serial BCD adder/subtractor.
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;
    localparam int BCD_MAX     = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic isInvalidDigit(input logic [BCD_DIGIT_W-1:0] d);
        return int'(d) > BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Single BCD digit add/subtract cell: subtract uses the 9's complement of b.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] a,
    input  logic [BCD_DIGIT_W-1:0] b,
    input  logic                   cin,
    input  logic                   mode,
    output logic [BCD_DIGIT_W-1:0] digit,
    output logic                   cout
);

    logic [BCD_DIGIT_W-1:0] w_bEff;
    logic [BCD_DIGIT_W:0]   w_total;

    // Non-BCD inputs go through the same arithmetic with 4-bit wraparound.
    always_comb begin
        w_bEff  = mode ? (4'(BCD_MAX) - b) : b;
        w_total = {1'b0, a} + {1'b0, w_bEff} + {4'b0000, cin};
        if (w_total > 5'(BCD_MAX)) begin
            digit = 4'(w_total - 5'd10);
            cout  = 1'b1;
        end else begin
            digit = w_total[BCD_DIGIT_W-1:0];
            cout  = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_addsub_seq.sv
// Digit-serial BCD add/subtract, one digit per clock, LSD first.
// Optional invalid-digit flag output enabled by defining BCD_INVALID_CHECK_EN.
module bcd_addsub_seq
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        mode,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] a,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] b,
    input  logic                        cin,
    output logic                        busy,
    output logic                        done,
    output logic [BCD_DIGIT_W*DIGITS-1:0] sum,
    output logic                        cout
`ifdef BCD_INVALID_CHECK_EN
    ,
    output logic                        err
`endif
);

    localparam int W     = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIGITS - 1);

    state_t                 r_state;
    logic [W-1:0]           r_a;
    logic [W-1:0]           r_b;
    logic [W-1:0]           r_work;
    logic                   r_mode;
    logic                   r_carry;
    logic [CNT_W-1:0]       r_cnt;

    logic [BCD_DIGIT_W-1:0] w_aDig;
    logic [BCD_DIGIT_W-1:0] w_bDig;
    logic [BCD_DIGIT_W-1:0] w_digit;
    logic                   w_carryOut;
    logic [W-1:0]           w_workNext;

    always_comb begin
        w_aDig     = r_a[int'(r_cnt)*BCD_DIGIT_W +: BCD_DIGIT_W];
        w_bDig     = r_b[int'(r_cnt)*BCD_DIGIT_W +: BCD_DIGIT_W];
        w_workNext = r_work;
        w_workNext[int'(r_cnt)*BCD_DIGIT_W +: BCD_DIGIT_W] = w_digit;
    end

    bcd_digit_add u_digit (
        .a     (w_aDig),
        .b     (w_bDig),
        .cin   (r_carry),
        .mode  (r_mode),
        .digit (w_digit),
        .cout  (w_carryOut)
    );

`ifdef BCD_INVALID_CHECK_EN
    logic w_invalid;

    always_comb begin
        w_invalid = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (isInvalidDigit(r_a[i*BCD_DIGIT_W +: BCD_DIGIT_W]) ||
                isInvalidDigit(r_b[i*BCD_DIGIT_W +: BCD_DIGIT_W]))
                w_invalid = 1'b1;
        end
    end
`endif

    // DONE accepts start directly so back-to-back operations skip IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_work  <= '0;
            r_mode  <= 1'b0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
`ifdef BCD_INVALID_CHECK_EN
            err     <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_mode  <= mode;
                        r_carry <= mode ? ~cin : cin;
                        r_cnt   <= '0;
                        r_work  <= '0;
                        busy    <= 1'b1;
                        r_state <= RUN;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_work  <= w_workNext;
                    r_carry <= w_carryOut;
                    if (r_cnt == LAST) begin
                        sum     <= w_workNext;
                        cout    <= w_carryOut;
                        done    <= 1'b1;
                        busy    <= 1'b0;
`ifdef BCD_INVALID_CHECK_EN
                        err     <= w_invalid;
`endif
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_addsub_seq.sv
// Directed-vector bench for bcd_addsub_seq (DIGITS=4); also covers the
// BCD_INVALID_CHECK_EN flag when that macro is defined.
module tb_bcd_addsub_seq;

    localparam int DIGITS   = 4;
    localparam int W        = 4 * DIGITS;
    localparam int MAX_WAIT = 40;
    localparam int NVEC     = 10;

    logic         clk   = 1'b0;
    logic         rst   = 1'b0;
    logic         start = 1'b0;
    logic         mode  = 1'b0;
    logic         cin   = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy;
    logic         done;
    logic         cout;
    logic [W-1:0] sum;
`ifdef BCD_INVALID_CHECK_EN
    logic         err;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         mode;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
    } vec_t;

    vec_t vecs[NVEC];

    bcd_addsub_seq #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .mode  (mode),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef BCD_INVALID_CHECK_EN
        ,
        .err   (err)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Drives one start request; returns #1 after the edge that samples it.
    task automatic applyStimulus(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                 input logic im, input logic ic);
        @(negedge clk);
        a     = ia;
        b     = ib;
        mode  = im;
        cin   = ic;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitDone(input int startCycles, output int cycles, output int busyLow);
        cycles  = startCycles;
        busyLow = 0;
        while (!done && cycles < MAX_WAIT) begin
            @(posedge clk);
            #1;
            cycles++;
            if (!done && !busy) busyLow++;
        end
    endtask

    task automatic runVector(input int idx);
        int cyc;
        int bl;
        applyStimulus(vecs[idx].a, vecs[idx].b, vecs[idx].mode, vecs[idx].cin);
        checkOutput($sformatf("v%0d busy at start", idx), busy, 1);
        waitDone(0, cyc, bl);
        checkOutput($sformatf("v%0d done", idx), done, 1);
        checkOutput($sformatf("v%0d latency", idx), cyc, DIGITS);
        checkOutput($sformatf("v%0d busy dropped early", idx), bl, 0);
        checkOutput($sformatf("v%0d busy at done", idx), busy, 0);
        checkOutput($sformatf("v%0d sum", idx), sum, vecs[idx].sum);
        checkOutput($sformatf("v%0d cout", idx), cout, vecs[idx].cout);
        @(posedge clk);
        #1;
        checkOutput($sformatf("v%0d done pulse width", idx), done, 0);
        checkOutput($sformatf("v%0d sum hold", idx), sum, vecs[idx].sum);
    endtask

    initial begin
        int cyc;
        int bl;
        int sawDone;

        vecs[0] = '{16'h1234, 16'h8766, 1'b0, 1'b0, 16'h0000, 1'b1};
        vecs[1] = '{16'h9999, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1};
        vecs[2] = '{16'h5000, 16'h1234, 1'b1, 1'b0, 16'h3766, 1'b1};
        vecs[3] = '{16'h1234, 16'h5000, 1'b1, 1'b0, 16'h6234, 1'b0};
        vecs[4] = '{16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0};
        vecs[5] = '{16'h4321, 16'h1111, 1'b0, 1'b1, 16'h5433, 1'b0};
        vecs[6] = '{16'h9999, 16'h9999, 1'b0, 1'b1, 16'h9999, 1'b1};
        vecs[7] = '{16'h0000, 16'h0001, 1'b1, 1'b0, 16'h9999, 1'b0};
        vecs[8] = '{16'h5555, 16'h5555, 1'b1, 1'b1, 16'h9999, 1'b0};
        vecs[9] = '{16'h0042, 16'h0041, 1'b1, 1'b1, 16'h0000, 1'b1};

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("reset busy", busy, 0);
        checkOutput("reset done", done, 0);
        checkOutput("reset sum", sum, 0);
        checkOutput("reset cout", cout, 0);
`ifdef BCD_INVALID_CHECK_EN
        checkOutput("reset err", err, 0);
`endif
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < NVEC; i++) runVector(i);

        // Start during RUN is ignored, then back-to-back start from DONE
        applyStimulus(16'h1234, 16'h8766, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        a     = 16'h5000;
        b     = 16'h1234;
        mode  = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitDone(2, cyc, bl);
        checkOutput("ignore-start done", done, 1);
        checkOutput("ignore-start latency", cyc, DIGITS);
        checkOutput("ignore-start sum", sum, 16'h0000);
        checkOutput("ignore-start cout", cout, 1);
        a     = 16'h5000;
        b     = 16'h1234;
        mode  = 1'b1;
        cin   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("b2b done cleared", done, 0);
        checkOutput("b2b busy", busy, 1);
        checkOutput("b2b sum held", sum, 16'h0000);
        waitDone(0, cyc, bl);
        checkOutput("b2b latency", cyc, DIGITS);
        checkOutput("b2b sum", sum, 16'h3766);
        checkOutput("b2b cout", cout, 1);
        @(posedge clk);
        #1;

        // Reset in the middle of RUN
        runVector(5);
        applyStimulus(16'h1234, 16'h8766, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("midrun-reset busy", busy, 0);
        checkOutput("midrun-reset done", done, 0);
        checkOutput("midrun-reset sum", sum, 0);
        checkOutput("midrun-reset cout", cout, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        sawDone = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (done) sawDone = 1;
        end
        checkOutput("midrun-reset no done", sawDone, 0);
        checkOutput("midrun-reset idle busy", busy, 0);
        runVector(0);

`ifdef BCD_INVALID_CHECK_EN
        applyStimulus(16'h12A4, 16'h0001, 1'b0, 1'b0);
        waitDone(0, cyc, bl);
        checkOutput("invalid done", done, 1);
        checkOutput("invalid err", err, 1);
        checkOutput("invalid sum", sum, 16'h1305);
        checkOutput("invalid cout", cout, 0);
        @(posedge clk);
        #1;
        runVector(2);
        checkOutput("valid err cleared", err, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
